// File: rtl/vector_rotate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_rotate_sequencer
// Description : Time-multiplexes one shared 8-bit rotate unit across the
//               lanes of a vector operand, one lane per clock cycle.
//               A command is taken over a valid/ready handshake. The operand,
//               direction and amount are captured so the inputs are free to
//               change afterwards. Each lane result from the rotate unit is
//               registered into the output vector. The assembled vector is
//               then returned over a second valid/ready handshake.
//               A zero rotate amount bypasses the rotate unit entirely.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   1          clock, rising edge
//   rst          in   1          asynchronous reset, active-high
//   start_valid  in   1          command valid
//   start_ready  out  1          command ready (IDLE only)
//   dir          in   1          rotate direction, 1 = right, 0 = left
//   amount       in   3          rotate amount 0..7
//   vec_in       in   LANES*8    operand, lane i = bits [8i+7:8i]
//   rot_select   out  1          to rotate unit: direction
//   rot_ent1     out  8          to rotate unit: lane data
//   rot_ent2     out  3          to rotate unit: amount
//   rot_result   in   8          from rotate unit, combinational
//   done_valid   out  1          result vector valid
//   done_ready   in   1          result vector consumed
//   vec_out      out  LANES*8    result vector
//   busy         out  1          high in RUN or DONE
// ============================================================================
module vector_rotate_sequencer #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic               dir,
    input  logic [2:0]         amount,
    input  logic [LANES*8-1:0] vec_in,
    output logic               rot_select,
    output logic [7:0]         rot_ent1,
    output logic [2:0]         rot_ent2,
    input  logic [7:0]         rot_result,
    output logic               done_valid,
    input  logic               done_ready,
    output logic [LANES*8-1:0] vec_out,
    output logic               busy
);

    // Lane counter width; derived from LANES and never overridden.
    localparam int IDX_W = $clog2(LANES);

    // Index of the final lane.
    localparam logic [IDX_W-1:0] c_LAST_LANE = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IDX_W-1:0]   r_lane;
    logic [LANES*8-1:0] r_vec;
    logic               r_dir;
    logic [2:0]         r_amt;
    logic [LANES*8-1:0] r_out;

    logic               w_accept;
    logic               w_bypass;
    logic               w_last_lane;
    logic [7:0]         w_lanes [LANES];

    // ------------------------------------------------------------------------
    // Unpack the captured operand into a lane array so that the rotate-unit
    // data mux is a plain array select on the lane counter.
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < LANES; g++) begin : g_unpack
            assign w_lanes[g] = r_vec[g*8 +: 8];
        end
    endgenerate

    assign w_accept    = start_valid && (r_state == S_IDLE);
    assign w_bypass    = (amount == 3'd0);
    assign w_last_lane = (r_lane == c_LAST_LANE);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b0;
        rot_select  = 1'b0;
        rot_ent1    = 8'h00;
        rot_ent2    = 3'd0;

        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (w_accept) begin
                    // A zero amount is an identity rotate, so skip the lane walk.
                    w_state_nxt = w_bypass ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                busy       = 1'b1;
                rot_select = r_dir;
                rot_ent1   = w_lanes[r_lane];
                rot_ent2   = r_amt;
                if (w_last_lane) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                busy       = 1'b1;
                done_valid = 1'b1;
                if (done_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Command capture, lane counter and result assembly.
    // The captured copies decouple the lane walk from the command inputs.
    // r_out is only written on a bypass load or a RUN lane write, so it keeps
    // the previous result through DONE backpressure and the following IDLE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane <= '0;
            r_vec  <= '0;
            r_dir  <= 1'b0;
            r_amt  <= 3'd0;
            r_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_lane <= '0;
                        if (w_bypass) begin
                            r_out <= vec_in;
                        end else begin
                            r_vec <= vec_in;
                            r_dir <= dir;
                            r_amt <= amount;
                        end
                    end
                end

                S_RUN: begin
                    r_out[r_lane*8 +: 8] <= rot_result;
                    // Hold at zero after the last lane rather than wrapping
                    // into an extra lane.
                    if (w_last_lane) begin
                        r_lane <= '0;
                    end else begin
                        r_lane <= r_lane + 1'b1;
                    end
                end

                default: begin
                    r_lane <= r_lane;
                end
            endcase
        end
    end

    assign vec_out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_vector_rotate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_rotate_sequencer
// Description : Directed self-checking bench for vector_rotate_sequencer.
//               The external rotate unit is modelled as a true 8-bit rotate.
//               Expected vectors are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_rotate_sequencer;

    localparam int LANES = 4;

    logic               clk;
    logic               rst;
    logic               start_valid;
    logic               start_ready;
    logic               dir;
    logic [2:0]         amount;
    logic [LANES*8-1:0] vec_in;
    logic               rot_select;
    logic [7:0]         rot_ent1;
    logic [2:0]         rot_ent2;
    logic [7:0]         rot_result;
    logic               done_valid;
    logic               done_ready;
    logic [LANES*8-1:0] vec_out;
    logic               busy;

    int errors = 0;
    int checks = 0;

    vector_rotate_sequencer #(.LANES(LANES)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .dir         (dir),
        .amount      (amount),
        .vec_in      (vec_in),
        .rot_select  (rot_select),
        .rot_ent1    (rot_ent1),
        .rot_ent2    (rot_ent2),
        .rot_result  (rot_result),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .vec_out     (vec_out),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rotate unit model.
    logic [15:0] w_dbl_r;
    logic [15:0] w_dbl_l;
    always_comb begin
        w_dbl_r    = {rot_ent1, rot_ent1} >> rot_ent2;
        w_dbl_l    = {rot_ent1, rot_ent1} << rot_ent2;
        rot_result = rot_select ? w_dbl_r[7:0] : w_dbl_l[15:8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".start_ready"}, 32'(start_ready), 32'd1);
        chk({tag, ".done_valid"},  32'(done_valid),  32'd0);
        chk({tag, ".busy"},        32'(busy),        32'd0);
        chk({tag, ".vec_out"},     vec_out,          32'h0);
        chk({tag, ".rot_select"},  32'(rot_select),  32'd0);
        chk({tag, ".rot_ent1"},    32'(rot_ent1),    32'd0);
        chk({tag, ".rot_ent2"},    32'(rot_ent2),    32'd0);
    endtask

    logic [7:0] exp_lanes [4];

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        dir         = 1'b0;
        amount      = 3'd0;
        vec_in      = '0;
        done_ready  = 1'b0;

        // ---------------- reset state ----------------
        step();
        chk_reset_outputs("reset");
        step();
        rst = 1'b0;

        // ---------------- right rotate by 1 ----------------
        start_valid = 1'b1;
        vec_in      = 32'h81F00F01;
        dir         = 1'b1;
        amount      = 3'd1;
        exp_lanes   = '{8'h01, 8'h0F, 8'hF0, 8'h81};
        step();                                   // accept edge k
        start_valid = 1'b0;
        chk("t1.start_ready_run", 32'(start_ready), 32'd0);
        chk("t1.busy_run",        32'(busy),        32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1.rot_ent1[%0d]", i), 32'(rot_ent1), 32'(exp_lanes[i]));
            chk($sformatf("t1.rot_sel[%0d]", i),  32'(rot_select), 32'd1);
            chk($sformatf("t1.rot_amt[%0d]", i),  32'(rot_ent2), 32'd1);
            chk($sformatf("t1.not_done[%0d]", i), 32'(done_valid), 32'd0);
            step();
        end
        chk("t1.done_valid", 32'(done_valid), 32'd1);   // after edge k+4
        chk("t1.vec_out",    vec_out,         32'hC0788780);
        chk("t1.rot_ent1_done", 32'(rot_ent1), 32'd0);
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        chk("t1.idle_ready", 32'(start_ready), 32'd1);
        chk("t1.idle_hold",  vec_out,          32'hC0788780);

        // ---------------- left rotate by 3 ----------------
        start_valid = 1'b1;
        vec_in      = 32'h00000096;
        dir         = 1'b0;
        amount      = 3'd3;
        step();
        start_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2.rot_sel[%0d]", i), 32'(rot_select), 32'd0);
            chk($sformatf("t2.rot_amt[%0d]", i), 32'(rot_ent2),   32'd3);
            step();
        end
        chk("t2.done_valid", 32'(done_valid), 32'd1);
        chk("t2.vec_out",    vec_out,         32'h000000B4);
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;

        // ---------------- bypass (amount 0) ----------------
        start_valid = 1'b1;
        vec_in      = 32'h12345678;
        dir         = 1'b1;
        amount      = 3'd0;
        step();                                   // accept edge k
        start_valid = 1'b0;
        chk("t3.done_valid", 32'(done_valid), 32'd1);   // after edge k+1
        chk("t3.vec_out",    vec_out,         32'h12345678);
        chk("t3.rot_ent1",   32'(rot_ent1),   32'd0);
        chk("t3.busy",       32'(busy),       32'd1);
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        chk("t3.idle_rot_ent1", 32'(rot_ent1), 32'd0);

        // ---------------- backpressure ----------------
        start_valid = 1'b1;
        vec_in      = 32'h12345678;
        dir         = 1'b1;
        amount      = 3'd4;
        step();
        vec_in = 32'hA5A5A5A5;                    // next command, bypass
        amount = 3'd0;
        for (int i = 0; i < 3; i++) begin         // RUN, start_valid still high
            chk($sformatf("t4.run_ready[%0d]", i), 32'(start_ready), 32'd0);
            step();
        end
        step();                                   // last lane edge -> DONE
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4.bp_valid[%0d]", i), 32'(done_valid),  32'd1);
            chk($sformatf("t4.bp_vec[%0d]", i),   vec_out,          32'h21436587);
            chk($sformatf("t4.bp_ready[%0d]", i), 32'(start_ready), 32'd0);
            chk($sformatf("t4.bp_busy[%0d]", i),  32'(busy),        32'd1);
            step();
        end
        chk("t4.still_done", 32'(done_valid), 32'd1);
        done_ready = 1'b1;
        step();                                   // DONE -> IDLE
        done_ready = 1'b0;
        chk("t4.idle_ready", 32'(start_ready), 32'd1);
        chk("t4.idle_valid", 32'(done_valid),  32'd0);
        chk("t4.idle_vec",   vec_out,          32'h21436587);
        step();                                   // accepted in that IDLE cycle
        start_valid = 1'b0;
        chk("t4.next_valid", 32'(done_valid), 32'd1);
        chk("t4.next_vec",   vec_out,         32'hA5A5A5A5);
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;

        // ---------------- reset mid-RUN ----------------
        start_valid = 1'b1;
        vec_in      = 32'h04030201;
        dir         = 1'b1;
        amount      = 3'd2;
        step();                                   // accept
        start_valid = 1'b0;
        step();                                   // lane 0 written
        step();                                   // lane 1 written
        chk("t5.partial", vec_out & 32'h0000FFFF, 32'h00008040);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("t5.rst");
        rst = 1'b0;
        start_valid = 1'b1;
        vec_in      = 32'h80402010;
        dir         = 1'b0;
        amount      = 3'd1;
        step();
        start_valid = 1'b0;
        step(); step(); step(); step();
        chk("t5.done_valid", 32'(done_valid), 32'd1);
        chk("t5.vec_out",    vec_out,         32'h01804020);
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;

        // ---------------- input churn during RUN ----------------
        start_valid = 1'b1;
        vec_in      = 32'hF00FAA55;
        dir         = 1'b1;
        amount      = 3'd3;
        step();
        for (int i = 0; i < 4; i++) begin
            vec_in      = $urandom;
            dir         = ~dir;
            amount      = 3'($urandom_range(0, 7));
            start_valid = 1'($urandom_range(0, 1));
            chk($sformatf("t6.rot_sel[%0d]", i), 32'(rot_select), 32'd1);
            chk($sformatf("t6.rot_amt[%0d]", i), 32'(rot_ent2),   32'd3);
            step();
        end
        start_valid = 1'b0;
        chk("t6.done_valid", 32'(done_valid), 32'd1);
        chk("t6.vec_out",    vec_out,         32'h1EE155AA);
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        chk("t6.idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_rotate_sequencer.md
Name: vector_rotate_sequencer

Overview:
Sequences one shared 8-bit circular-shift (rotate) unit across all lanes of a vector operand, one lane per cycle. Accepts a vector rotate command over a valid/ready handshake and drives the rotate unit's select, data and amount inputs. Registers each lane result and returns the assembled vector over a second valid/ready handshake. Sits between the vector issue stage and the lane-scalar rotate datapath.

Parameters:
LANES, 4, number of 8-bit lanes per vector; must be >= 2.
IDX_W, $clog2(LANES), lane counter width; derived, not overridden.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
start_valid  input  1  command valid.
start_ready  output  1  command accepted when valid and ready are both high at a rising edge.
dir  input  1  rotate direction: 1 = right, 0 = left.
amount  input  3  rotate amount, 0..7.
vec_in  input  LANES*8  operand; lane i = bits [8i+7:8i].
rot_select  output  1  to rotate unit, direction.
rot_ent1  output  8  to rotate unit, lane data.
rot_ent2  output  3  to rotate unit, amount.
rot_result  input  8  from rotate unit; combinational, valid in the same cycle.
done_valid  output  1  result vector valid.
done_ready  input  1  result consumed when valid and ready are both high at a rising edge.
vec_out  output  LANES*8  result vector, same lane packing as vec_in.
busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Reset (async, rst=1) forces IDLE, lane counter 0, and clears all captured registers. Reset outputs: start_ready=1, done_valid=0, busy=0, vec_out=0, rot_select=0, rot_ent1=0, rot_ent2=0.
- IDLE: start_ready=1.
  - On accept with amount!=0: capture vec_in, dir and amount; set lane=0; go to RUN.
  - On accept with amount==0: load vec_out=vec_in and go straight to DONE (bypass; rotate unit is not driven).
- RUN: start_ready=0. Each cycle drive rot_ent1=captured lane[lane], rot_select=captured dir, rot_ent2=captured amount. At the rising edge, write rot_result into vec_out lane[lane] and increment lane. After the edge that writes lane LANES-1, go to DONE. The lane counter does not wrap into an extra cycle.
- Latency: with accept at edge k, done_valid is high after edge k+LANES. For amount==0 it is high after edge k+1.
- DONE: done_valid=1; vec_out is held stable while done_ready=0 (backpressure of unlimited length). On done_ready=1, go to IDLE. There is no accept in DONE, so there is at least one IDLE cycle between commands.
- Outside RUN, rot_select, rot_ent1 and rot_ent2 are driven to 0.
- vec_out changes only during RUN lane writes, on a bypass load, or on reset. It keeps its value in IDLE until the next command.
- start_valid is ignored in RUN and DONE. Inputs may change freely after the accept edge, because the captured copies are used.
- If rst is asserted mid-RUN or in DONE, the operation is abandoned with no done_valid pulse and outputs go immediately to their reset values.

Test Plan:
- LANES=4, vec_in=0x81F00F01, dir=1, amount=1, rotate unit modelled as a true rotate. Required: rot_ent1 sequence 0x01, 0x0F, 0xF0, 0x81 on consecutive cycles; done_valid after accept edge +4; vec_out=0xC0788780.
- Left rotate: vec_in=0x00000096, dir=0, amount=3. Required: lane0 result 0xB4, other lanes 0x00; rot_select=0 and rot_ent2=3 throughout RUN.
- Bypass: amount=0, vec_in=0x12345678. Required: done_valid after accept edge +1; vec_out=0x12345678; rot_ent1 stays 0.
- Backpressure: hold done_ready=0 for 3 cycles in DONE, with start_valid=1 throughout. Required: done_valid and vec_out stable, start_ready=0, busy=1. Then done_ready=1 leads to one IDLE cycle with start_ready=1, and the new command is accepted there.
- Reset mid-RUN: assert rst asynchronously after lane 1 is written. Required in the same cycle: start_ready=1, done_valid=0, busy=0, vec_out=0, rot_* all 0. After release, a fresh command completes correctly.
- Input churn: change vec_in, dir and amount every cycle during RUN. Required: results reflect only the values captured at accept.
